seq_addsub: RTL and testbench

SEQ_ADDSUB -- requirements
Module: seq_addsub

---
 rtl/seq_addsub.sv | 115 +++++++++++
 tb/tb_seq_addsub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// and publishes result plus ALU flags only when the whole word is complete.
module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_result;
    logic [KW-1:0]    r_k;
    logic             r_c;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_sum_ext;
    logic [WIDTH-1:0] w_shadow_next;
    logic             w_last;
    logic             w_accept;
    logic             w_ovf;

    // Operands shift right each RUN edge so the active chunk is always the
    // low CHUNK bits; sum chunks enter the shadow from the top.
    always_comb begin
        w_sum         = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, r_c};
        w_sum_ext     = WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK);
        w_shadow_next = (r_shadow >> CHUNK) | w_sum_ext;
        // carry into MSB recovered as sum_msb ^ a_msb ^ b_msb
        w_ovf         = w_shadow_next[WIDTH-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1]
                        ^ w_sum[CHUNK];
        w_last        = (r_k == KW'(NCH - 1));
        w_accept      = start && (r_state != RUN);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_shadow   <= '0;
            r_k        <= '0;
            r_c        <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= op ? ~b : b;
            r_k <= '0;
            r_c <= op;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> CHUNK;
            r_b      <= r_b >> CHUNK;
            r_c      <= w_sum[CHUNK];
            r_shadow <= w_shadow_next;
            r_k      <= r_k + KW'(1);
            if (w_last) begin
                r_result   <= w_shadow_next;
                r_carry    <= w_sum[CHUNK];
                r_overflow <= w_ovf;
                r_zero     <= (w_shadow_next == '0);
                r_negative <= w_shadow_next[WIDTH-1];
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign zero     = r_zero;
    assign negative = r_negative;
endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed vectors, random ops against an
// arithmetic reference model, and multi-cycle corner sequences.
module tb_seq_addsub;
    logic        clk, rst, start, op;
    logic [7:0]  a, b, result;
    logic        busy, done, carry, overflow, zero, negative;
    logic        start2, op2;
    logic [15:0] a2, b2, result2;
    logic        busy2, done2, carry2, overflow2, zero2, negative2;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [15:0] res; logic c, v, z, n; } exp_t;
    typedef struct { logic op; logic [7:0] a, b, res; logic c, v, z, n; } vec_t;

    seq_addsub #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .overflow(overflow), .zero(zero), .negative(negative));

    seq_addsub #(.WIDTH(16), .CHUNK(16)) dut_w (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2), .carry(carry2),
        .overflow(overflow2), .zero(zero2), .negative(negative2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic, then reduce to w bits.
    function automatic exp_t model(input int w, input logic o,
                                   input longint unsigned x, input longint unsigned y);
        exp_t r;
        longint unsigned m = (64'd1 << w) - 1;
        longint top = longint'(64'd1 << (w - 1));
        longint sx = longint'(x);
        longint sy = longint'(y);
        longint sr;
        longint unsigned u;
        if (sx >= top) sx -= 2 * top;
        if (sy >= top) sy -= 2 * top;
        if (!o) begin
            u = x + y;  r.c = (u > m);   sr = sx + sy;
        end else begin
            u = x - y;  r.c = (x >= y);  sr = sx - sy;
        end
        u = u & m;
        r.res = 16'(u);
        r.v = (sr >= top) || (sr < -top);
        r.z = (u == 0);
        r.n = u[w-1];
        return r;
    endfunction

    task automatic run_op(input string nm, input logic o, input logic [7:0] x,
                          input logic [7:0] y, input exp_t e);
        logic [7:0] prev;
        int nbusy;
        logic held;
        prev = result;
        op = o; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
        nbusy = 0;
        held = 1'b1;
        while (busy && nbusy < 20) begin
            nbusy++;
            if (result !== prev || done) held = 1'b0;
            tick;
        end
        check({nm, "_busy_cycles"}, 32'(nbusy), 32'd2);
        check({nm, "_no_partial"}, 32'(held), 32'd1);
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_result"}, 32'(result), 32'(e.res[7:0]));
        check({nm, "_flags_cvzn"}, {28'd0, carry, overflow, zero, negative},
              {28'd0, e.c, e.v, e.z, e.n});
        tick;
        check({nm, "_done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        exp_t e;
        int t1, t2, nd, bad;
        logic [7:0] rx, ry;
        logic ro;

        vecs[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        start2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0;
        tick;
        check("reset_outputs", {22'd0, busy, done, result}, 32'd0);
        check("reset_flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
        check("reset_wide", {13'd0, busy2, done2, carry2, result2}, 32'd0);
        #2 rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            e = '{16'(vecs[i].res), vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n};
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        for (int i = 0; i < 40; i++) begin
            rx = 8'($urandom); ry = 8'($urandom); ro = 1'($urandom);
            if (i == 0) begin rx = 8'h80; ry = 8'h80; ro = 1'b0; end
            run_op($sformatf("rnd%0d", i), ro, rx, ry, model(8, ro, rx, ry));
        end

        // start pulsed mid-RUN with different operands is ignored
        op = 1'b0; a = 8'h12; b = 8'h34; start = 1'b1;
        tick;
        op = 1'b1; a = 8'hFF; b = 8'hFF;
        tick;
        start = 1'b0;
        tick;
        check("midrun_done", 32'(done), 32'd1);
        check("midrun_result", 32'(result), 32'h46);
        tick;
        check("midrun_idle", 32'({busy, done}), 32'd0);

        // start held through DONE: back-to-back with NCH+1 spacing
        op = 1'b0; a = 8'h10; b = 8'h20; start = 1'b1;
        tick;
        op = 1'b1; a = 8'h03; b = 8'h01;
        t1 = -1; t2 = -1; nd = 0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    t1 = c;
                    check("b2b_first", 32'(result), 32'h30);
                end else if (nd == 2) begin
                    t2 = c;
                    check("b2b_second", 32'({carry, result}), 32'h102);
                end
            end
            if (t1 > 0 && c == t1 + 1) start = 1'b0;
        end
        check("b2b_pulses", 32'(nd), 32'd2);
        check("b2b_spacing", 32'(t2 - t1), 32'd3);

        // reset between the two RUN edges of 0xFF+0x01
        run_op("pre_rst", 1'b0, 8'h7F, 8'h01, model(8, 1'b0, 8'h7F, 8'h01));
        op = 1'b0; a = 8'hFF; b = 8'h01; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2 rst = 1'b1;
        #1;
        check("arst_outputs", {22'd0, busy, done, result}, 32'd0);
        check("arst_flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
        tick;
        tick;
        #2 rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (busy || done || result != 8'h00 || carry || zero) bad++;
        end
        check("arst_aborted", 32'(bad), 32'd0);

        // start held during reset only accepted after release
        op = 1'b0; a = 8'hFF; b = 8'h01; start = 1'b1; rst = 1'b1;
        tick;
        check("rst_start_blocked", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        tick;
        check("rst_start_accepted", 32'(busy), 32'd1);
        start = 1'b0;
        bad = 0;
        while (!done && bad < 20) begin bad++; tick; end
        check("rst_start_done", 32'(done), 32'd1);
        check("rst_start_result", 32'({carry, zero, result}), 32'h300);
        tick;

        // single-chunk wide instance
        op2 = 1'b0; a2 = 16'h8000; b2 = 16'h8000; start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check("wide_busy", 32'({busy2, done2}), 32'd2);
        tick;
        check("wide_done", 32'({busy2, done2}), 32'd1);
        check("wide_result", 32'(result2), 32'h0000);
        check("wide_flags_cvzn", {28'd0, carry2, overflow2, zero2, negative2}, 32'hE);
        tick;
        check("wide_done_pulse", 32'(done2), 32'd0);
        for (int i = 0; i < 10; i++) begin
            a2 = 16'($urandom); b2 = 16'($urandom); op2 = 1'($urandom);
            e = model(16, op2, a2, b2);
            start2 = 1'b1;
            tick;
            start2 = 1'b0;
            tick;
            check($sformatf("wrnd%0d_done", i), 32'(done2), 32'd1);
            check($sformatf("wrnd%0d_result", i), 32'(result2), 32'(e.res));
            check($sformatf("wrnd%0d_flags", i), {28'd0, carry2, overflow2, zero2, negative2},
                  {28'd0, e.c, e.v, e.z, e.n});
            tick;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
